// File: rtl/uart_word_assembler.sv
// Packs bytes from a UART receiver into words, queues completed words in a small FIFO,
// and presents them on a valid/ready interface with timeout abort and overflow reporting.
module uart_word_assembler #(
    parameter int WORD_WIDTH     = 16,
    parameter int LSB_FIRST      = 1,
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            uart_byte_ready,
    input  logic [7:0]                      uart_byte,
    output logic [WORD_WIDTH-1:0]           word_data,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            timeout_err
);

    localparam int BPW    = WORD_WIDTH / 8;
    localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BPW - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST =
        (TIMEOUT_CYCLES > 0) ? TCNT_W'(TIMEOUT_CYCLES - 1) : TCNT_W'(0);
    localparam logic [SYNC_STAGES:0] EDGE_PATTERN = {1'b0, {SYNC_STAGES{1'b1}}};

    function automatic logic [WORD_WIDTH-1:0] insert_byte(
        input logic [WORD_WIDTH-1:0] w,
        input logic [IDX_W-1:0]      i,
        input logic [7:0]            b
    );
        logic [WORD_WIDTH-1:0] r;
        r = w;
        for (int j = 0; j < BPW; j++) begin
            if (i == IDX_W'(j)) begin
                if (LSB_FIRST != 0) r[8*j +: 8] = b;
                else                r[WORD_WIDTH-1-8*j -: 8] = b;
            end
        end
        return r;
    endfunction

    logic [SYNC_STAGES:0]  rdy_hist;
    logic [IDX_W-1:0]      idx;
    logic [WORD_WIDTH-1:0] word_buf;
    logic [WORD_WIDTH-1:0] word_next;
    logic [TCNT_W-1:0]     tcnt;
    logic                  capture;
    logic                  last_byte;
    logic                  expire;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  accept;

    // Capture only once the history shows a low sample followed by SYNC_STAGES highs,
    // which both qualifies stability and limits capture to one per excursion.
    assign capture   = (rdy_hist == EDGE_PATTERN);
    assign last_byte = (idx == IDX_LAST);
    assign word_next = insert_byte(word_buf, idx, uart_byte);
    assign expire    = (TIMEOUT_CYCLES > 0) && (idx != '0) && !capture && (tcnt == TCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_hist    <= '1;
            idx         <= '0;
            word_buf    <= '0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            rdy_hist    <= {rdy_hist[SYNC_STAGES-1:0], uart_byte_ready};
            timeout_err <= expire;
            if (capture) begin
                tcnt <= '0;
                if (last_byte) begin
                    idx      <= '0;
                    word_buf <= '0;
                end else begin
                    idx      <= idx + IDX_W'(1);
                    word_buf <= word_next;
                end
            end else if (expire) begin
                idx      <= '0;
                word_buf <= '0;
                tcnt     <= '0;
            end else if ((TIMEOUT_CYCLES > 0) && (idx != '0)) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
        end
    end

    // Output FIFO: a push while full proceeds only if the head leaves at the same edge.
    assign push       = capture && last_byte;
    assign word_valid = (fifo_count != '0);
    assign pop        = word_valid && word_ready;
    assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign accept     = push && (!full || pop);
    assign word_data  = word_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= word_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (!accept && pop) fifo_count <= fifo_count - CNT_W'(1);
            if (push && !accept)     overflow <= 1'b1;
        end
    end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Parametrised successor to the UART byte-to-word shift register.
- Takes bytes from the UART receiver and detects each new byte with a synchronised, stability-qualified edge on uart_byte_ready.
- Packs BYTES_PER_WORD bytes into one word in a selectable byte order, queues completed words in a small FIFO, and presents them on a valid/ready interface to the loader or CPU side.
- Adds things the single-word block lacks: abort of a partial word after an inter-byte timeout, output backpressure, and overflow reporting.

Parameters:
- WORD_WIDTH, 16, output word width; must be a multiple of 8 and at least 8. BYTES_PER_WORD = WORD_WIDTH/8.
- LSB_FIRST, 1, 1: the first received byte lands in bits [7:0]. 0: the first received byte lands in the top byte.
- SYNC_STAGES, 3, number of consecutive high samples of uart_byte_ready required before capture; at least 1.
- FIFO_DEPTH, 4, number of output word entries; a power of two, at least 2.
- TIMEOUT_CYCLES, 0, idle clk cycles allowed between bytes of one word before the partial word is discarded; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_byte_ready  in  1  UART receive strobe/level; asynchronous to clk
- uart_byte  in  8  received byte; stable while uart_byte_ready is high
- word_data  out  WORD_WIDTH  head-of-FIFO word
- word_valid  out  1  FIFO not empty
- word_ready  in  1  consumer accepts word_data this cycle
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of queued words
- overflow  out  1  sticky: a completed word was dropped
- timeout_err  out  1  one-cycle pulse: a partial word was discarded

Behaviour:
- Reset (rst=1 at a clk edge):
  - word_valid=0, fifo_count=0, overflow=0, timeout_err=0, word_data=0.
  - Byte index=0, partial word cleared, FIFO pointers=0, timeout counter=0.
  - Sample history set to all ones, so a uart_byte_ready held high through reset produces no capture.
  - Reset mid-word discards the partial word silently; no timeout_err.
- Sampling:
  - uart_byte_ready is sampled every clk edge into a history of SYNC_STAGES+1 bits.
  - Capture happens at the edge where the history shows one low sample followed by SYNC_STAGES high samples.
  - If the first high sample is at edge k, capture is at edge k+SYNC_STAGES; uart_byte is sampled at that edge.
  - One capture per low-to-high excursion; staying high gives no further captures. Pulses shorter than SYNC_STAGES samples are ignored.
- Packing:
  - Byte index i (0..BYTES_PER_WORD-1) is written to bits [8i+7:8i] when LSB_FIRST=1, and to bits [WORD_WIDTH-1-8i -: 8] when LSB_FIRST=0.
  - The index increments per capture and wraps to 0 after the last byte.
- Completion:
  - On capture of the last byte, the full word, including that byte, is pushed into the FIFO at the same edge.
  - word_valid and fifo_count reflect the push the next cycle, so latency is 1 cycle from final capture to visibility.
- Handshake:
  - A pop occurs at an edge where word_valid and word_ready are both 1.
  - word_data is combinational from the head entry; it is stable while word_valid=1 and not popped.
  - word_ready while the FIFO is empty has no effect.
- Full FIFO:
  - A push with fifo_count==FIFO_DEPTH and no simultaneous pop drops the word and sets overflow; overflow clears only on rst.
  - Push and pop at the same edge while full: both proceed, count unchanged, no overflow.
  - Push and pop at the same edge while empty: the word is queued, count becomes 1.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter runs only while byte index>0 and resets to 0 on each capture.
  - When it reaches TIMEOUT_CYCLES: index returns to 0, the partial word is cleared, timeout_err pulses for 1 cycle, and the counter returns to 0.
  - A capture on the same edge as expiry wins: the byte is accepted, the counter is cleared, and no timeout_err is raised.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH; fifo_count is kept as an explicit counter.

Test Plan:
- Reset with uart_byte_ready held high, then release rst -> no capture and word_valid=0; after byte_ready drops and rises for bytes 0x34 then 0x12 (defaults) -> word_data=0x1234 and word_valid=1 one cycle after the second capture.
- LSB_FIRST=0, WORD_WIDTH=32, bytes 0xDE,0xAD,0xBE,0xEF -> word_data=0xDEADBEEF.
- uart_byte_ready high-pulse of 2 cycles with SYNC_STAGES=3 -> no capture and byte index unchanged; a 3-cycle pulse -> capture at edge k+3.
- word_ready=0, FIFO_DEPTH=4, send 5 words -> fifo_count=4, overflow=1, and the popped sequence is the first 4 words in order; then pop and push at the same edge while full -> count stays 4 and nothing is dropped.
- TIMEOUT_CYCLES=100, send 1 byte then idle 100 cycles -> timeout_err pulses once, index=0; next two bytes 0xAA,0x55 -> word_data=0x55AA.
- Assert rst after the first byte of a word -> all outputs at reset values, no timeout_err; the following full word assembles correctly.
